muldiv_seq: RTL and testbench

Sequencer that executes all eight RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on the team's existing unsigned multi-cycle multiply/divide engine. The engine has ports valid, mode, in_A, in_B, ready and out[63:0], and supports only multu and divu.
- Before issue: converts signed operands to magnitudes and resolves divide-by-zero and signed overflow without using the engine.
- After completion: applies sign correction and selects the 32-bit result half.
- Sits between the EX stage and the engine; stalls the pipeline while busy.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_seq_if.sv | 19 +
 rtl/muldiv_fixup.sv | 37 +++
 rtl/muldiv_seq.sv | 147 ++++++++++++++
 tb/tb_muldiv_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M sequencer: funct3 codes, FSM encoding and
// the architectural constants for the divide corner cases.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFix,
    StDone,
    StDrain
  } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Handshake between the sequencer (master) and the unsigned mul/div engine (slave).
interface muldiv_seq_if;
  logic        md_valid;
  logic        md_mode;
  logic [31:0] md_in_A;
  logic [31:0] md_in_B;
  logic        md_ready;
  logic [63:0] md_out;

  modport master (
    output md_valid, md_mode, md_in_A, md_in_B,
    input  md_ready, md_out
  );

  modport slave (
    input  md_valid, md_mode, md_in_A, md_in_B,
    output md_ready, md_out
  );
endinterface

// File: rtl/muldiv_fixup.sv
// Turns the unsigned engine result into the RV32M rd value: sign correction
// and selection of the relevant 32-bit half.
module muldiv_fixup
  import muldiv_pkg::*;
(
  input  logic [63:0] md_out_i,
  input  logic [2:0]  funct3_i,
  input  logic        neg_a_i,
  input  logic        neg_b_i,
  output logic [31:0] result_o
);

  logic        neg_res;
  logic [31:0] quot, rem, prod_hi;

  assign neg_res = neg_a_i ^ neg_b_i;
  assign quot    = md_out_i[31:0];
  assign rem     = md_out_i[63:32];

  // Upper half of the 64-bit negation: ~hi plus the carry out of ~lo + 1.
  assign prod_hi = neg_res ? (~md_out_i[63:32] + {31'd0, (md_out_i[31:0] == 32'd0)})
                           : md_out_i[63:32];

  always_comb begin
    result_o = '0;
    unique case (funct3_i)
      F3_MUL:             result_o = md_out_i[31:0];
      F3_MULH, F3_MULHSU: result_o = prod_hi;
      F3_MULHU:           result_o = md_out_i[63:32];
      F3_DIV:             result_o = neg_res ? (~quot + 32'd1) : quot;
      F3_DIVU:            result_o = quot;
      F3_REM:             result_o = neg_a_i ? (~rem + 32'd1) : rem;
      F3_REMU:            result_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M sequencer around an unsigned multi-cycle mul/div engine: operand sign
// stripping, divide corner-case bypass, issue/wait control and result fixup.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [2:0]   funct3,
  input  logic [31:0]  rs1,
  input  logic [31:0]  rs2,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic [31:0]  result,
  output logic         err,
  muldiv_seq_if.master md
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [31:0]       mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [31:0]       result_q, result_d;
  logic [63:0]       out_q, out_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              accept, sign_a_op, sign_b_op, div0, ovf, bypass, timeout_hit;
  logic [31:0]       bypass_res, fix_res;

  always_comb begin
    sign_a_op  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
    sign_b_op  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    div0       = funct3[2] && (rs2 == 32'd0);
    ovf        = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    bypass     = div0 || ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    bypass_res = div0 ? (funct3[1] ? rs1 : DIV0_Q) : (funct3[1] ? 32'd0 : INT_MIN);
  end

  assign accept      = (state_q == StIdle) && req_valid && !kill;
  assign timeout_hit = (cnt_q == CntLast);

  muldiv_fixup u_fixup (
    .md_out_i (out_q),
    .funct3_i (f3_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .result_o (fix_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = bypass ? StDone : StIssue;
      StIssue: state_d = kill ? StDrain : StWait;
      StWait: begin
        if (md.md_ready)      state_d = kill ? StIdle : StFix;
        else if (timeout_hit) state_d = StIdle;
        else if (kill)        state_d = StDrain;
      end
      StDrain: if (md.md_ready || timeout_hit) state_d = StIdle;
      StFix:   state_d = kill ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone) && !kill;
    err         = ((state_q == StWait) || (state_q == StDrain)) && !md.md_ready && timeout_hit;
    result      = result_q;
    md.md_valid = (state_q == StIssue);
    md.md_mode  = f3_q[2];
    md.md_in_A  = mag_a_q;
    md.md_in_B  = mag_b_q;
  end

  // Datapath next-state
  always_comb begin
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    result_d = result_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    if (accept) begin
      f3_d    = funct3;
      neg_a_d = sign_a_op && rs1[31];
      neg_b_d = sign_b_op && rs2[31];
      mag_a_d = neg_a_d ? (~rs1 + 32'd1) : rs1;
      mag_b_d = neg_b_d ? (~rs2 + 32'd1) : rs2;
      if (bypass) result_d = bypass_res;
    end
    if ((state_q == StWait) && md.md_ready) out_d = md.md_out;
    if ((state_q == StFix) && !kill) result_d = fix_res;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (((state_q == StWait) || (state_q == StDrain)) && !md.md_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      result_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
    end else begin
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      result_q <= result_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural engine and an RV32M
// reference computed with native signed/unsigned arithmetic.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned TO = 63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, err;
  logic [31:0] result;

  muldiv_seq_if mdi ();

  muldiv_seq #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .md        (mdi.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          bypass;
    logic [31:0] res;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          acc_cyc = 0, mdv_cyc = 0, rdy_cyc = 0, mdv_cnt = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic        last_mode = 1'b0;
  int          eng_lat = 0;
  bit          eng_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      F3_MUL:    return pu[31:0];
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  return pu[63:32];
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_bypass(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    return (f[2] && b == 0) ||
           ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural unsigned engine
  initial begin
    logic [31:0] ea, eb;
    logic [63:0] o;
    int          lat;
    mdi.md_ready = 1'b0;
    mdi.md_out   = '0;
    forever begin
      @(negedge clk);
      if (mdi.md_valid && !eng_hold) begin
        ea = mdi.md_in_A;
        eb = mdi.md_in_B;
        if (!mdi.md_mode) o = {32'd0, ea} * {32'd0, eb};
        else if (eb != 0) o = {ea % eb, ea / eb};
        else o = '0;
        lat = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 6));
        repeat (lat) @(posedge clk);
        #1 mdi.md_ready = 1'b1;
        mdi.md_out = o;
        @(posedge clk);
        #1 mdi.md_ready = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && !busy && !kill) acc_cyc = cyc;
      if (mdi.md_valid) begin
        mdv_cnt++;
        mdv_cyc   = cyc;
        last_a    = mdi.md_in_A;
        last_b    = mdi.md_in_B;
        last_mode = mdi.md_mode;
      end
      if (mdi.md_ready) rdy_cyc = cyc;
      if (done) begin
        if (sbq.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          e = sbq.pop_front();
          if (e.is_err) chk("done_instead_of_err", 64'(done), 64'd0);
          else begin
            chk("result", 64'(result), 64'(e.res));
            chk("done_latency", 64'(cyc - (e.bypass ? acc_cyc : rdy_cyc)),
                e.bypass ? 64'd1 : 64'd2);
          end
        end
      end
      if (err) begin
        if (sbq.size() == 0) chk("err_unexpected", 64'(err), 64'd0);
        else begin
          e = sbq.pop_front();
          if (!e.is_err) chk("err_instead_of_done", 64'(err), 64'd0);
          else chk("timeout_cycles", 64'(cyc - mdv_cyc), 64'(TO));
        end
      end
    end
  end

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input bit expect_err);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    funct3    = f;
    rs1       = a;
    rs2       = b;
    if (push) begin
      e.is_err = expect_err;
      e.bypass = is_bypass(f, a, b);
      e.res    = ref_model(f, a, b);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy) chk("busy_stuck", 64'(busy), 64'd0);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = mdv_cnt;
    start_op(f, a, b, 1'b1, 1'b0);
    wait_idle(200);
    @(negedge clk);
    chk("md_valid_pulses", 64'(mdv_cnt - n0), is_bypass(f, a, b) ? 64'd0 : 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit busy_dropped;
    bit rdy_seen;

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_md_ctrl", {62'd0, mdi.md_valid, mdi.md_mode}, 64'd0);
    chk("rst_md_in", {mdi.md_in_A, mdi.md_in_B}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    chk("mul_in_A", 64'(last_a), 64'd7);
    chk("mul_in_B", 64'(last_b), 64'hFFFF_FFFD);
    chk("mul_mode", 64'(last_mode), 64'd0);
    do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000);
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(F3_DIV,    32'hFFFF_FFF9, 32'd2);
    chk("div_in_A", 64'(last_a), 64'd7);
    chk("div_in_B", 64'(last_b), 64'd2);
    chk("div_mode", 64'(last_mode), 64'd1);
    do_op(F3_REM,    32'hFFFF_FFF9, 32'd2);
    do_op(F3_DIVU,   32'd100, 32'd7);
    do_op(F3_REMU,   32'd100, 32'd7);
    do_op(F3_DIVU,   32'h1234, 32'd0);
    do_op(F3_REMU,   32'h1234, 32'd0);
    do_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    do_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);

    // Kill 5 cycles into WAIT: no done, busy held until md_ready
    eng_lat = 12;
    start_op(F3_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    busy_dropped = 1'b0;
    rdy_seen     = 1'b0;
    for (int i = 0; i < 40 && !rdy_seen; i++) begin
      @(negedge clk);
      if (mdi.md_ready) rdy_seen = 1'b1;
      else if (!busy) busy_dropped = 1'b1;
    end
    chk("kill_ready_seen", 64'(rdy_seen), 64'd1);
    chk("kill_busy_held", 64'(busy_dropped), 64'd0);
    @(negedge clk);
    chk("kill_busy_released", 64'(busy), 64'd0);

    // Asynchronous reset in WAIT
    start_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done_err", {62'd0, done, err}, 64'd0);
    chk("arst_md_ctrl", {62'd0, mdi.md_valid, mdi.md_mode}, 64'd0);
    chk("arst_md_in", {mdi.md_in_A, mdi.md_in_B}, 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    eng_lat = 0;

    // Engine never responds: err after TIMEOUT cycles, no done
    eng_hold = 1'b1;
    start_op(F3_MULHU, 32'd3, 32'd5, 1'b1, 1'b1);
    wait_idle(TO + 20);
    eng_hold = 1'b0;
    @(negedge clk);
    chk("timeout_idle", 64'(busy), 64'd0);

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
